// File: rtl/memory_top.sv
// Memory stage of the 5-stage RISC-V pipeline: issues loads/stores over a
// req/ack data-memory port, extends load data and drives the M/W pipeline register.
module memory_top #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            MemoryOpM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [ADDR_WIDTH-1:0] RdM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  MisalignedM,
  output logic                  MemTimeoutM,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [ADDR_WIDTH-1:0] RdW,
  output logic [DATA_WIDTH-1:0] PCPlus4W
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [DATA_WIDTH-1:0] capture_reg;
  logic                  timed_out_reg;

  logic                  access;
  logic                  size_half;
  logic                  size_word;
  logic                  misaligned;
  logic                  aligned_access;
  logic                  busy;
  logic                  timeout_hit;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] read_data_int;
  logic [3:0]            lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;

  assign access         = (ResultSrcM == 2'b01) | MemWriteM;
  assign size_half      = (MemoryOpM[1:0] == 2'b01);
  assign size_word      = (MemoryOpM[1:0] == 2'b10);
  assign misaligned     = (size_half & ALUResultM[0]) | (size_word & (|ALUResultM[1:0]));
  assign aligned_access = access & ~misaligned;

  // busy covers the whole outstanding access; the M register is frozen meanwhile,
  // which is what keeps addr/we/wdata/be stable while mem_req is high.
  assign busy        = ~reset & (((state_reg == ST_IDLE) & aligned_access) | (state_reg == ST_WAIT));
  assign timeout_hit = (state_reg == ST_WAIT) & (cnt_reg == CNT_LAST) & ~mem_ack;

  always_comb begin
    load_byte = 8'h00;
    case (ALUResultM[1:0])
      2'd0:    load_byte = mem_rdata[7:0];
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      default: load_byte = mem_rdata[31:24];
    endcase
    load_half = ALUResultM[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (MemoryOpM[1:0])
      2'b00:   load_ext = {{(DATA_WIDTH-8){~MemoryOpM[2] & load_byte[7]}}, load_byte};
      2'b01:   load_ext = {{(DATA_WIDTH-16){~MemoryOpM[2] & load_half[15]}}, load_half};
      default: load_ext = mem_rdata;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_be[gi] = (MemoryOpM[1:0] == 2'b00) ? (ALUResultM[1:0] == 2'(gi)) :
                         (MemoryOpM[1:0] == 2'b01) ? (ALUResultM[1] == 1'(gi / 2)) : 1'b1;
    assign lane_wdata[8*gi +: 8] = (MemoryOpM[1:0] == 2'b00) ? WriteDataM[7:0] :
                                   (MemoryOpM[1:0] == 2'b01) ? WriteDataM[8*(gi % 2) +: 8] :
                                                               WriteDataM[8*gi +: 8];
  end

  assign mem_req     = busy;
  assign StallM      = busy;
  assign mem_we      = busy & MemWriteM;
  assign mem_addr    = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
  assign mem_wdata   = lane_wdata;
  assign mem_be      = busy ? lane_be : 4'b0000;
  assign MisalignedM = ~reset & (state_reg == ST_IDLE) & access & misaligned;
  assign MemTimeoutM = ~reset & timeout_hit;

  assign read_data_int = (state_reg == ST_DONE) ? capture_reg : load_ext;
  assign ReadDataM     = reset ? '0 : read_data_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      capture_reg   <= '0;
      timed_out_reg <= 1'b0;
      RegWriteW     <= 1'b0;
      ResultSrcW    <= 2'b00;
      ALUResultW    <= '0;
      ReadDataW     <= '0;
      RdW           <= '0;
      PCPlus4W      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (aligned_access) begin
            cnt_reg       <= '0;
            timed_out_reg <= 1'b0;
            if (mem_ack) begin
              capture_reg <= load_ext;
              state_reg   <= ST_DONE;
            end else begin
              state_reg   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (mem_ack) begin
            capture_reg <= load_ext;
            state_reg   <= ST_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            // An aborted access leaves zero as its load value.
            capture_reg   <= '0;
            timed_out_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (!busy) begin
        RegWriteW  <= RegWriteM & ~(access & misaligned) &
                      ~((state_reg == ST_DONE) & timed_out_reg);
        ResultSrcW <= ResultSrcM;
        ALUResultW <= ALUResultM;
        ReadDataW  <= read_data_int;
        RdW        <= RdM;
        PCPlus4W   <= PCPlus4M;
      end
    end
  end

endmodule

// File: tb/tb_memory_top.sv
// Randomized bench for memory_top: a transaction-level model predicts every
// cycle's outputs from the chosen ack delay; directed cases pin literal values.
module tb_memory_top;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          RegWriteM;
  logic [1:0]    ResultSrcM;
  logic          MemWriteM;
  logic [2:0]    MemoryOpM;
  logic [DW-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [AW-1:0] RdM;
  logic          mem_req, mem_we, mem_ack;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_be;
  logic          StallM, MisalignedM, MemTimeoutM, RegWriteW;
  logic [DW-1:0] ReadDataM, ALUResultW, ReadDataW, PCPlus4W;
  logic [1:0]    ResultSrcW;
  logic [AW-1:0] RdW;

  memory_top #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .MemoryOpM(MemoryOpM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .StallM(StallM), .ReadDataM(ReadDataM), .MisalignedM(MisalignedM),
    .MemTimeoutM(MemTimeoutM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  int txn_id   = 0;

  // Expected combinational outputs for the current cycle
  logic        e_req, e_stall, e_mis, e_to, e_we;
  logic [31:0] e_addr, e_wdata, e_rdm;
  logic [3:0]  e_be;
  // Expected W register, and what it loads at the next edge if not stalled
  logic        ew_rw, pw_rw;
  logic [1:0]  ew_rs, pw_rs;
  logic [31:0] ew_alu, ew_rdd, ew_pc, pw_alu, pw_rdd, pw_pc;
  logic [4:0]  ew_rd, pw_rd;
  // Per-transaction observations of the DUT for the literal checks
  int          o_stalls, o_reqs, o_mis, o_to;
  logic [31:0] o_rdm, o_wdata;
  logic [3:0]  o_be;
  logic        o_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int f_size(input logic [2:0] op);
    return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic f_mis(input logic [2:0] op, input logic [31:0] addr);
    return (int'(addr[1:0]) % f_size(op)) != 0;
  endfunction

  function automatic logic [31:0] f_ext(input logic [2:0] op, input logic [31:0] addr,
                                        input logic [31:0] w);
    logic [31:0] sh;
    if (f_size(op) == 1) begin
      sh = w >> (8 * int'(addr[1:0]));
      return op[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    end else if (f_size(op) == 2) begin
      sh = w >> (16 * int'(addr[1]));
      return op[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    end
    return w;
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] op, input logic [31:0] addr);
    logic [3:0] be;
    int off;
    off = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + f_size(op));
    return be;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % f_size(op)) +: 8];
    return r;
  endfunction

  task automatic set_exp(input logic req, input logic stall, input logic mis, input logic to,
                         input logic [31:0] rdm);
    e_req = req; e_stall = stall; e_mis = mis; e_to = to; e_rdm = rdm;
    e_we    = req & MemWriteM;
    e_addr  = {ALUResultM[31:2], 2'b00};
    e_be    = req ? f_be(MemoryOpM, ALUResultM) : 4'b0000;
    e_wdata = f_wdata(MemoryOpM, WriteDataM);
  endtask

  task automatic set_pw(input logic rw, input logic [31:0] rdd);
    pw_rw = rw; pw_rs = ResultSrcM; pw_alu = ALUResultM; pw_rdd = rdd;
    pw_rd = RdM; pw_pc = PCPlus4M;
  endtask

  task automatic sample_dut();
    #2;
    if (StallM === 1'b1) o_stalls++;
    if (mem_req === 1'b1) begin
      o_reqs++; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
    end
    if (MisalignedM === 1'b1) o_mis++;
    if (MemTimeoutM === 1'b1) o_to++;
    o_rdm = ReadDataM;
  endtask

  task automatic cycle_end();
    @(posedge clk); #1;
    if (reset) begin
      ew_rw = 0; ew_rs = 0; ew_alu = 0; ew_rdd = 0; ew_rd = 0; ew_pc = 0;
    end else if (!e_stall) begin
      ew_rw = pw_rw; ew_rs = pw_rs; ew_alu = pw_alu; ew_rdd = pw_rdd; ew_rd = pw_rd; ew_pc = pw_pc;
    end
  endtask

  // delay: cycles from request to ack (0 = same cycle); negative means never ack
  task automatic run_txn(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] pc4, input int delay, input logic [31:0] rdata);
    logic acc, mis;
    int last;
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; MemoryOpM = op;
    ALUResultM = addr; WriteDataM = wd; RdM = rd; PCPlus4M = pc4;
    o_stalls = 0; o_reqs = 0; o_mis = 0; o_to = 0; o_rdm = 0; o_wdata = 0; o_be = 0; o_we = 0;
    acc = (rs == 2'b01) || mw;
    mis = acc && f_mis(op, addr);
    if (!acc || mis) begin
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      set_exp(1'b0, 1'b0, mis, 1'b0, f_ext(op, addr, mem_rdata));
      set_pw(rw & ~mis, f_ext(op, addr, mem_rdata));
      sample_dut(); cycle_end();
    end else begin
      last = (delay < 0) ? TO : delay;
      for (int i = 0; i <= last; i++) begin
        mem_ack   = (i == delay);
        mem_rdata = (i == delay) ? rdata : $urandom;
        set_exp(1'b1, 1'b1, 1'b0, (delay < 0) && (i == TO), f_ext(op, addr, mem_rdata));
        sample_dut(); cycle_end();
      end
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      set_exp(1'b0, 1'b0, 1'b0, 1'b0, (delay < 0) ? 32'h0 : f_ext(op, addr, rdata));
      set_pw(rw & (delay >= 0), e_rdm);
      sample_dut(); cycle_end();
    end
    txn_id++;
    $display("txn %0d rs=%0d mw=%0d op=%0d addr=%h delay=%0d stalls=%0d rdm=%h",
             txn_id, rs, mw, op, addr, delay, o_stalls, o_rdm);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("StallM", 32'(StallM), 32'(e_stall));
      chk("MisalignedM", 32'(MisalignedM), 32'(e_mis));
      chk("MemTimeoutM", 32'(MemTimeoutM), 32'(e_to));
      chk("mem_be", 32'(mem_be), 32'(e_be));
      chk("ReadDataM", ReadDataM, e_rdm);
      if (e_req) begin
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      chk("RegWriteW", 32'(RegWriteW), 32'(ew_rw));
      chk("ResultSrcW", 32'(ResultSrcW), 32'(ew_rs));
      chk("ALUResultW", ALUResultW, ew_alu);
      chk("ReadDataW", ReadDataW, ew_rdd);
      chk("RdW", 32'(RdW), 32'(ew_rd));
      chk("PCPlus4W", PCPlus4W, ew_pc);
    end
  end

  initial begin
    logic [2:0] ops [5];
    logic [2:0] op;
    logic [1:0] rs;
    logic [31:0] addr;
    logic mw;
    int kind, dly;
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    reset = 1'b1; RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0; MemoryOpM = 0;
    ALUResultM = 0; WriteDataM = 0; RdM = 0; PCPlus4M = 0; mem_ack = 0; mem_rdata = 0;
    set_exp(0, 0, 0, 0, 32'h0);
    set_pw(0, 32'h0);
    ew_rw = 0; ew_rs = 0; ew_alu = 0; ew_rdd = 0; ew_rd = 0; ew_pc = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    cycle_end(); cycle_end();
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_RegWriteW", 32'(RegWriteW), 32'h0);
    reset = 1'b0;

    // LW, ack three cycles after the request
    run_txn(1, 2'b01, 0, 3'd2, 32'h100, 32'h0, 5'd7, 32'h44, 3, 32'hDEADBEEF);
    chk("lw_stalls", 32'(o_stalls), 32'd4);
    chk("lw_done_rdm", o_rdm, 32'hDEADBEEF);
    chk("lw_ReadDataW", ReadDataW, 32'hDEADBEEF);
    chk("lw_RdW", 32'(RdW), 32'd7);
    // byte/half loads with same-cycle ack
    run_txn(1, 2'b01, 0, 3'd0, 32'h103, 32'h0, 5'd3, 32'h48, 0, 32'h80112233);
    chk("lb_stalls", 32'(o_stalls), 32'd1);
    chk("lb_rdm", o_rdm, 32'hFFFFFF80);
    run_txn(1, 2'b01, 0, 3'd4, 32'h103, 32'h0, 5'd3, 32'h4C, 0, 32'h80112233);
    chk("lbu_rdm", o_rdm, 32'h00000080);
    run_txn(1, 2'b01, 0, 3'd5, 32'h102, 32'h0, 5'd4, 32'h50, 0, 32'h80112233);
    chk("lhu_rdm", o_rdm, 32'h00008011);
    // stores
    run_txn(0, 2'b00, 1, 3'd0, 32'h101, 32'h000000AB, 5'd0, 32'h54, 1, 32'h0);
    chk("sb_we", 32'(o_we), 32'h1);
    chk("sb_be", 32'(o_be), 32'b0010);
    chk("sb_wdata", o_wdata, 32'hABABABAB);
    run_txn(0, 2'b00, 1, 3'd1, 32'h102, 32'h00001234, 5'd0, 32'h58, 2, 32'h0);
    chk("sh_be", 32'(o_be), 32'b1100);
    chk("sh_wdata", o_wdata, 32'h12341234);
    // misaligned LW
    run_txn(1, 2'b01, 0, 3'd2, 32'h102, 32'h0, 5'd9, 32'h5C, 0, 32'h0);
    chk("mis_reqs", 32'(o_reqs), 32'd0);
    chk("mis_pulse", 32'(o_mis), 32'd1);
    chk("mis_stalls", 32'(o_stalls), 32'd0);
    chk("mis_RegWriteW", 32'(RegWriteW), 32'h0);
    // timeout: never ack
    run_txn(1, 2'b01, 0, 3'd2, 32'h200, 32'h0, 5'd10, 32'h60, -1, 32'h0);
    chk("to_stalls", 32'(o_stalls), 32'd5);
    chk("to_pulses", 32'(o_to), 32'd1);
    chk("to_RegWriteW", 32'(RegWriteW), 32'h0);

    // reset in the second WAIT cycle, then a late ack in IDLE
    RegWriteM = 1; ResultSrcM = 2'b01; MemWriteM = 0; MemoryOpM = 3'd2;
    ALUResultM = 32'h300; WriteDataM = 0; RdM = 5'd12; PCPlus4M = 32'h64;
    o_reqs = 0;
    for (int i = 0; i < 2; i++) begin
      mem_ack = 0; mem_rdata = $urandom;
      set_exp(1, 1, 0, 0, f_ext(MemoryOpM, ALUResultM, mem_rdata));
      cycle_end();
    end
    reset = 1'b1; mem_ack = 0;
    set_exp(0, 0, 0, 0, 32'h0);
    cycle_end();
    reset = 1'b0;
    RegWriteM = 0; ResultSrcM = 0; MemoryOpM = 0; ALUResultM = 0; RdM = 0; PCPlus4M = 0;
    mem_ack = 1'b1; mem_rdata = 32'h0;
    set_exp(0, 0, 0, 0, 32'h0);
    set_pw(0, 32'h0);
    sample_dut();
    chk("rst_wait_req", 32'(o_reqs), 32'd0);
    chk("rst_wait_RdW", 32'(RdW), 32'h0);
    chk("rst_wait_PCPlus4W", PCPlus4W, 32'h0);
    cycle_end();
    chk("late_ack_RegWriteW", 32'(RegWriteW), 32'h0);
    chk("late_ack_ReadDataW", ReadDataW, 32'h0);
    $display("txn reset-mid-wait done");

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      rs = (kind == 1) ? 2'b01 : (kind == 3) ? 2'b10 : 2'b00;
      mw = (kind == 2);
      op = mw ? ops[$urandom_range(0, 2)] : ops[$urandom_range(0, 4)];
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = addr[1:0] & ~2'(f_size(op) - 1);
      dly = $urandom_range(0, TO + 1);
      if (dly > TO) dly = -1;
      run_txn(1'($urandom_range(0, 1)), rs, mw, op, addr, $urandom, 5'($urandom),
              $urandom, dly, $urandom);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
